// File: rtl/fp_bcd_formatter_if.sv
// Handshake and result bundle between a floating-point producer and the BCD formatter.
interface fp_bcd_formatter_if;
    logic        start;
    logic [31:0] value_754;
    logic [31:0] bcd_digits;
    logic        neg;
    logic        err;
    logic        ovf;
    logic        busy;
    logic        done;

    modport master (
        output start, value_754,
        input  bcd_digits, neg, err, ovf, busy, done
    );

    modport slave (
        input  start, value_754,
        output bcd_digits, neg, err, ovf, busy, done
    );
endinterface

// File: rtl/fp_bcd_formatter.sv
// Multi-cycle IEEE-754 single to 8-digit BCD converter (fixed-point scale, round, double-dabble).
// state | meaning
// IDLE  | waiting for start | LOAD | decode (1st cycle) then align (2nd) | SCALE | x10 per frac digit
// ROUND | half-up on magnitude | BCD | 27 double-dabble steps | DONE | one-cycle done pulse
module fp_bcd_formatter #(
    parameter int FRAC_DIGITS = 3
) (
    input  logic clk,
    input  logic rst,
    fp_bcd_formatter_if.slave bus
);
    localparam int S_IDLE  = 0;
    localparam int S_LOAD  = 1;
    localparam int S_SCALE = 2;
    localparam int S_ROUND = 3;
    localparam int S_BCD   = 4;
    localparam int S_DONE  = 5;

    localparam logic [5:0] ST_IDLE  = 6'b000001;
    localparam logic [5:0] ST_LOAD  = 6'b000010;
    localparam logic [5:0] ST_SCALE = 6'b000100;
    localparam logic [5:0] ST_ROUND = 6'b001000;
    localparam logic [5:0] ST_BCD   = 6'b010000;
    localparam logic [5:0] ST_DONE  = 6'b100000;

    localparam int          SCALE_LAST_I = (FRAC_DIGITS > 0) ? FRAC_DIGITS - 1 : 0;
    localparam logic [2:0]  SCALE_LAST   = 3'(SCALE_LAST_I);
    localparam logic [32:0] LIMIT        = 33'd100000000;

    logic [5:0]        state, next_state;
    logic [31:0]       op;
    logic              load_ph, cls_err, cls_big, q_nz;
    logic [23:0]       mant;
    logic signed [9:0] k, nk;
    logic [63:0]       fx, fx_aligned;
    logic [58:0]       dd, dd_step;
    logic [31:0]       adj;
    logic [2:0]        scale_cnt;
    logic [4:0]        bcd_cnt;
    logic [32:0]       q;
    logic              scale_ovf, round_ovf;
    logic [31:0]       digits_r;
    logic              neg_r, err_r, ovf_r;
    logic              busy_c, done_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (1'b1)
            state[S_IDLE]:  if (bus.start) next_state = ST_LOAD;
            state[S_LOAD]: begin
                if (load_ph) begin
                    if (cls_err || cls_big)    next_state = ST_DONE;
                    else if (FRAC_DIGITS == 0) next_state = ST_ROUND;
                    else                       next_state = ST_SCALE;
                end
            end
            state[S_SCALE]: begin
                if (scale_ovf)                    next_state = ST_DONE;
                else if (scale_cnt == SCALE_LAST) next_state = ST_ROUND;
            end
            state[S_ROUND]: next_state = round_ovf ? ST_DONE : ST_BCD;
            state[S_BCD]:   if (bcd_cnt == 5'd26) next_state = ST_DONE;
            state[S_DONE]:  next_state = ST_IDLE;
            default:        next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_c = ~state[S_IDLE];
        done_c = state[S_DONE];
    end

    // Alignment: {1,m} placed as Q32.32, i.e. shifted by E+9; far-right shifts flush to zero.
    always_comb begin
        nk         = -k;
        fx_aligned = '0;
        if (!k[9])                fx_aligned = {40'b0, mant} << k[5:0];
        else if (nk < 10'sd24)    fx_aligned = {40'b0, mant} >> nk[4:0];
    end

    always_comb begin
        scale_ovf = ({1'b0, fx[63:32]} >= LIMIT);
        q         = {1'b0, fx[63:32]} + {32'b0, fx[31]};
        round_ovf = (q >= LIMIT);
    end

    always_comb begin
        adj = dd[58:27];
        for (int d = 0; d < 8; d++) begin
            if (adj[d*4 +: 4] >= 4'd5) adj[d*4 +: 4] = adj[d*4 +: 4] + 4'd3;
        end
        dd_step = {adj[30:0], dd[26:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op        <= '0;
            load_ph   <= 1'b0;
            cls_err   <= 1'b0;
            cls_big   <= 1'b0;
            mant      <= '0;
            k         <= '0;
            fx        <= '0;
            dd        <= '0;
            q_nz      <= 1'b0;
            scale_cnt <= '0;
            bcd_cnt   <= '0;
            digits_r  <= '0;
            neg_r     <= 1'b0;
            err_r     <= 1'b0;
            ovf_r     <= 1'b0;
        end else begin
            if (state[S_IDLE] && bus.start) begin
                op        <= bus.value_754;
                load_ph   <= 1'b0;
                scale_cnt <= '0;
                bcd_cnt   <= '0;
            end
            if (state[S_LOAD]) begin
                if (!load_ph) begin
                    load_ph <= 1'b1;
                    cls_err <= &op[30:23];
                    cls_big <= op[30:23] > 8'd153;
                    mant    <= (op[30:23] == 8'd0) ? 24'd0 : {1'b1, op[22:0]};
                    k       <= $signed({2'b00, op[30:23]}) - 10'sd118;
                end else begin
                    load_ph <= 1'b0;
                    fx      <= fx_aligned;
                    if (cls_err) begin
                        digits_r <= '0;
                        neg_r    <= 1'b0;
                        err_r    <= 1'b1;
                        ovf_r    <= 1'b0;
                    end else if (cls_big) begin
                        digits_r <= '0;
                        neg_r    <= op[31];
                        err_r    <= 1'b0;
                        ovf_r    <= 1'b1;
                    end
                end
            end
            if (state[S_SCALE]) begin
                scale_cnt <= scale_cnt + 3'd1;
                if (scale_ovf) begin
                    digits_r <= '0;
                    neg_r    <= op[31];
                    err_r    <= 1'b0;
                    ovf_r    <= 1'b1;
                end else begin
                    fx <= (fx << 3) + (fx << 1);
                end
            end
            if (state[S_ROUND]) begin
                dd   <= {32'b0, q[26:0]};
                q_nz <= |q;
                if (round_ovf) begin
                    digits_r <= '0;
                    neg_r    <= op[31];
                    err_r    <= 1'b0;
                    ovf_r    <= 1'b1;
                end
            end
            if (state[S_BCD]) begin
                dd      <= dd_step;
                bcd_cnt <= bcd_cnt + 5'd1;
                if (bcd_cnt == 5'd26) begin
                    digits_r <= dd_step[58:27];
                    neg_r    <= op[31] & q_nz;
                    err_r    <= 1'b0;
                    ovf_r    <= 1'b0;
                end
            end
        end
    end

    assign bus.bcd_digits = digits_r;
    assign bus.neg        = neg_r;
    assign bus.err        = err_r;
    assign bus.ovf        = ovf_r;
    assign bus.busy       = busy_c;
    assign bus.done       = done_c;
endmodule

// File: tb/tb_fp_bcd_formatter.sv
// Directed bench for fp_bcd_formatter with FRAC_DIGITS=3; latencies counted in edges after the start edge.
module tb_fp_bcd_formatter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    fp_bcd_formatter_if bus ();

    fp_bcd_formatter #(.FRAC_DIGITS(3)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives a one-cycle start; returns just after edge 0, then scrambles the operand.
    task automatic launch(input logic [31:0] v);
        @(negedge clk);
        bus.value_754 = v;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.value_754 = ~v;
    endtask

    // Returns the edge index (relative to the caller's last edge) at which done is first seen, -1 on timeout.
    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({bus.bcd_digits, bus.neg, bus.err, bus.ovf, bus.busy, bus.done} !== 37'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h required 0",
                     {bus.bcd_digits, bus.neg, bus.err, bus.ovf, bus.busy, bus.done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_idle: busy/done got %b required 00", {bus.busy, bus.done});
        end
    endtask

    task automatic test_normal();
        logic [31:0] vin  [6] = '{32'h3FC00000, 32'hC2F6E979, 32'h3F2AAAAB,
                                  32'hB8D1B717, 32'h00000000, 32'h47C34FFF};
        logic [31:0] vexp [6] = '{32'h00001500, 32'h00123456, 32'h00000667,
                                  32'h00000000, 32'h00000000, 32'h99999992};
        logic        vneg [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        int n;
        for (int i = 0; i < 6; i++) begin
            launch(vin[i]);
            n_cmp++;
            if (bus.busy !== 1'b1) begin
                n_bad++;
                $display("FAIL normal_busy[%0d]: got %b required 1", i, bus.busy);
            end
            wait_done(n);
            n_cmp++;
            if ({bus.bcd_digits, bus.neg, bus.err, bus.ovf} !== {vexp[i], vneg[i], 2'b00}) begin
                n_bad++;
                $display("FAIL normal_result[%0d] in=%h: digits=%h neg=%b err=%b ovf=%b required digits=%h neg=%b err=0 ovf=0",
                         i, vin[i], bus.bcd_digits, bus.neg, bus.err, bus.ovf, vexp[i], vneg[i]);
            end
            n_cmp++;
            if (n !== 33) begin
                n_bad++;
                $display("FAIL normal_latency[%0d]: done at edge %0d required 33", i, n);
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if ({bus.done, bus.busy} !== 2'b00) begin
                n_bad++;
                $display("FAIL normal_after_done[%0d]: done/busy got %b required 00", i, {bus.done, bus.busy});
            end
        end
    endtask

    task automatic test_errors();
        logic [31:0] vin [3] = '{32'h7F800000, 32'h7FC00000, 32'hFF800000};
        int n;
        for (int i = 0; i < 3; i++) begin
            launch(vin[i]);
            wait_done(n);
            n_cmp++;
            if ({bus.bcd_digits, bus.neg, bus.err, bus.ovf} !== {32'd0, 1'b0, 1'b1, 1'b0}) begin
                n_bad++;
                $display("FAIL err_result[%0d] in=%h: digits=%h neg=%b err=%b ovf=%b required digits=0 neg=0 err=1 ovf=0",
                         i, vin[i], bus.bcd_digits, bus.neg, bus.err, bus.ovf);
            end
            n_cmp++;
            if (n !== 2) begin
                n_bad++;
                $display("FAIL err_latency[%0d]: done at edge %0d required 2", i, n);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_overflow();
        logic [31:0] vin  [4] = '{32'h4D000000, 32'h4CBEBC20, 32'h4B189680, 32'h47C35000};
        int          vedg [4] = '{2, 3, 4, 6};
        int n;
        for (int i = 0; i < 4; i++) begin
            launch(vin[i]);
            wait_done(n);
            n_cmp++;
            if ({bus.bcd_digits, bus.neg, bus.err, bus.ovf} !== {32'd0, 1'b0, 1'b0, 1'b1}) begin
                n_bad++;
                $display("FAIL ovf_result[%0d] in=%h: digits=%h neg=%b err=%b ovf=%b required digits=0 neg=0 err=0 ovf=1",
                         i, vin[i], bus.bcd_digits, bus.neg, bus.err, bus.ovf);
            end
            n_cmp++;
            if (n !== vedg[i]) begin
                n_bad++;
                $display("FAIL ovf_latency[%0d]: done at edge %0d required %0d", i, n, vedg[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_ignore_start();
        int n;
        launch(32'h3FC00000);
        @(negedge clk);
        bus.value_754 = 32'h7F800000;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(n);
        n_cmp++;
        if ({bus.bcd_digits, bus.neg, bus.err, bus.ovf} !== {32'h00001500, 3'b000}) begin
            n_bad++;
            $display("FAIL ignore_result: digits=%h neg=%b err=%b ovf=%b required digits=00001500 flags=000",
                     bus.bcd_digits, bus.neg, bus.err, bus.ovf);
        end
        n_cmp++;
        if (n + 1 !== 33) begin
            n_bad++;
            $display("FAIL ignore_latency: done at edge %0d required 33", n + 1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int n;
        launch(32'hC2F6E979);
        wait_done(n);
        bus.value_754 = 32'h3FC00000;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_done_start: busy got %b required 0", bus.busy);
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_accept: busy got %b required 1", bus.busy);
        end
        wait_done(n);
        n_cmp++;
        if ({bus.bcd_digits, bus.neg, n} !== {32'h00001500, 1'b0, 32'd33}) begin
            n_bad++;
            $display("FAIL b2b_result: digits=%h neg=%b edge=%0d required 00001500 0 33",
                     bus.bcd_digits, bus.neg, n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int n;
        int seen = 0;
        launch(32'hC2F6E979);
        wait_done(n);
        @(posedge clk);
        #1;
        launch(32'h3FC00000);
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.bcd_digits, bus.neg, bus.err, bus.ovf, bus.busy, bus.done} !== 37'd0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got %h required 0",
                     {bus.bcd_digits, bus.neg, bus.err, bus.ovf, bus.busy, bus.done});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL midreset_quiet: done/busy seen %0d cycles required 0", seen);
        end
        launch(32'h3FC00000);
        wait_done(n);
        n_cmp++;
        if ({bus.bcd_digits, bus.neg, bus.err, bus.ovf, n} !== {32'h00001500, 3'b000, 32'd33}) begin
            n_bad++;
            $display("FAIL midreset_next: digits=%h flags=%b edge=%0d required 00001500 000 33",
                     bus.bcd_digits, {bus.neg, bus.err, bus.ovf}, n);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.value_754 = 32'd0;
        #12;
        test_reset();
        test_normal();
        test_errors();
        test_overflow();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
